// File: rtl/rrq_parse.sv
// ---------------------------------------------------------------------------
// rrq_parse : TFTP request payload parser (filename + mode string)
//
// Sits downstream of opcode_decode. After req is seen it consumes the rest of
// the request from the same byte stream: a null-terminated filename (stored
// in an internal buffer) followed by a null-terminated mode string that must
// case-insensitively equal "octet" (or "netascii" when enabled).
//
// Optional feature macro: RRQ_NETASCII_EN
//   defined   -> "netascii" is accepted alongside "octet"; mode_netascii
//                reports which one matched.
//   undefined -> only "octet" is accepted; mode_netascii is constant 0.
//
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous active-high reset, clears all state
//   en            byte qualifier for eth_data
//   eth_data[7:0] payload byte
//   req           high while the current packet is a request
//   eof           one-cycle end-of-packet pulse
//   name_addr     filename buffer read address
//   name_data     registered filename byte (0x00 beyond name_len)
//   name_len      filename length excluding terminator
//   done          parse finished (sticky)
//   valid         parse succeeded (sticky)
//   err           parse failed (sticky)
//   err_code      0 none, 1 bad name, 2 bad mode, 3 truncated
//   mode_netascii accepted mode was netascii
// ---------------------------------------------------------------------------
module rrq_parse #(
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic [7:0]    eth_data,
    input  logic          req,
    input  logic          eof,
    input  logic [AW-1:0] name_addr,
    output logic [7:0]    name_data,
    output logic [AW:0]   name_len,
    output logic          done,
    output logic          valid,
    output logic          err,
    output logic [1:0]    err_code,
    output logic          mode_netascii
);

`ifdef RRQ_NETASCII_EN
    localparam bit NET_EN = 1'b1;
`else
    localparam bit NET_EN = 1'b0;
`endif

    localparam int          DEPTH    = 2 ** AW;
    localparam logic [AW:0] MAX_NAME = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] LEN_ONE  = {{AW{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_NAME = 3'd1,
        S_MODE = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    function automatic logic [7:0] oct_char(input logic [3:0] i);
        case (i)
            4'd0:    oct_char = 8'h6F; // o
            4'd1:    oct_char = 8'h63; // c
            4'd2:    oct_char = 8'h74; // t
            4'd3:    oct_char = 8'h65; // e
            4'd4:    oct_char = 8'h74; // t
            default: oct_char = 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] net_char(input logic [3:0] i);
        case (i)
            4'd0:    net_char = 8'h6E; // n
            4'd1:    net_char = 8'h65; // e
            4'd2:    net_char = 8'h74; // t
            4'd3:    net_char = 8'h61; // a
            4'd4:    net_char = 8'h73; // s
            4'd5:    net_char = 8'h63; // c
            4'd6:    net_char = 8'h69; // i
            4'd7:    net_char = 8'h69; // i
            default: net_char = 8'h00;
        endcase
    endfunction

    state_t        state_q, state_d;
    logic [AW:0]   len_q, len_d;
    logic [3:0]    idx_q, idx_d;
    logic          oct_ok_q, oct_ok_d;
    logic          net_ok_q, net_ok_d;
    logic [1:0]    code_q, code_d;
    logic          net_q, net_d;
    logic          done_q, valid_q, err_q;
    logic [7:0]    name_data_q;
    logic [7:0]    name_buf_q [0:DEPTH-1];
    logic          wr_en_s;
    logic [AW-1:0] wr_addr_s;
    logic [7:0]    fold_s;
    logic          oct_hit_s, net_hit_s;

    // Upper-case letters are folded to lower case before mode comparison;
    // a candidate only survives while its string still has characters left.
    assign fold_s    = ((eth_data >= 8'h41) && (eth_data <= 8'h5A)) ? (eth_data | 8'h20) : eth_data;
    assign oct_hit_s = oct_ok_q && (idx_q < 4'd5) && (fold_s == oct_char(idx_q));
    assign net_hit_s = NET_EN && net_ok_q && (idx_q < 4'd8) && (fold_s == net_char(idx_q));

    // Next-state logic: consume one qualified byte, then apply eof.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        idx_d     = idx_q;
        oct_ok_d  = oct_ok_q;
        net_ok_d  = net_ok_q;
        code_d    = code_q;
        net_d     = net_q;
        wr_en_s   = 1'b0;
        wr_addr_s = len_q[AW-1:0];
        if (en) begin
            case (state_q)
                S_IDLE: begin
                    if (!req) begin
                        state_d = S_IDLE;
                    end else if (eth_data == 8'h00) begin
                        state_d = S_ERR;
                        code_d  = 2'd1;
                    end else begin
                        wr_en_s   = 1'b1;
                        wr_addr_s = {AW{1'b0}};
                        len_d     = LEN_ONE;
                        state_d   = S_NAME;
                    end
                end
                S_NAME: begin
                    if (eth_data == 8'h00) begin
                        state_d  = S_MODE;
                        idx_d    = 4'd0;
                        oct_ok_d = 1'b1;
                        net_ok_d = NET_EN;
                    end else if (len_q == MAX_NAME) begin
                        state_d = S_ERR;
                        code_d  = 2'd1;
                    end else begin
                        wr_en_s = 1'b1;
                        len_d   = len_q + LEN_ONE;
                    end
                end
                S_MODE: begin
                    // Terminator is only accepted right after a full candidate.
                    if (eth_data == 8'h00) begin
                        if (oct_ok_q && (idx_q == 4'd5)) begin
                            state_d = S_DONE;
                            net_d   = 1'b0;
                        end else if (net_ok_q && (idx_q == 4'd8)) begin
                            state_d = S_DONE;
                            net_d   = 1'b1;
                        end else begin
                            state_d = S_ERR;
                            code_d  = 2'd2;
                        end
                    end else if (oct_hit_s || net_hit_s) begin
                        oct_ok_d = oct_hit_s;
                        net_ok_d = net_hit_s;
                        idx_d    = idx_q + 4'd1;
                    end else begin
                        state_d = S_ERR;
                        code_d  = 2'd2;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end else begin
            state_d = state_q;
        end
        // eof is judged on the post-byte state so a completing byte wins.
        if (eof && ((state_d == S_NAME) || (state_d == S_MODE))) begin
            state_d = S_ERR;
            code_d  = 2'd3;
        end else begin
            code_d = code_d;
        end
    end

    // Parser state and registered status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            len_q    <= {(AW+1){1'b0}};
            idx_q    <= 4'd0;
            oct_ok_q <= 1'b0;
            net_ok_q <= 1'b0;
            code_q   <= 2'd0;
            net_q    <= 1'b0;
            done_q   <= 1'b0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            idx_q    <= idx_d;
            oct_ok_q <= oct_ok_d;
            net_ok_q <= net_ok_d;
            code_q   <= code_d;
            net_q    <= net_d;
            done_q   <= (state_d == S_DONE) || (state_d == S_ERR);
            valid_q  <= (state_d == S_DONE);
            err_q    <= (state_d == S_ERR);
        end
    end

    // Filename storage; not reset because name_len gates every read.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            name_buf_q[wr_addr_s] <= eth_data;
        end
    end

    // Registered read port, returning 0x00 past the end of the name.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            name_data_q <= 8'h00;
        end else if ({1'b0, name_addr} < len_q) begin
            name_data_q <= name_buf_q[name_addr];
        end else begin
            name_data_q <= 8'h00;
        end
    end

    assign name_data     = name_data_q;
    assign name_len      = len_q;
    assign done          = done_q;
    assign valid         = valid_q;
    assign err           = err_q;
    assign err_code      = code_q;
    assign mode_netascii = NET_EN & net_q;

endmodule

// File: tb/tb_rrq_parse.sv
// Bench for rrq_parse: directed request packets, a string-level reference
// parser re-evaluated over the whole consumed byte history each cycle, and
// literal expectations for the headline cases.
module tb_rrq_parse;
    localparam int AW   = 5;
    localparam int MAXN = 32;
`ifdef RRQ_NETASCII_EN
    localparam bit NET = 1'b1;
`else
    localparam bit NET = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          en = 1'b0;
    logic [7:0]    eth_data = 8'h00;
    logic          req = 1'b0;
    logic          eof = 1'b0;
    logic [AW-1:0] name_addr = '0;
    logic [7:0]    name_data;
    logic [AW:0]   name_len;
    logic          done, valid, err, mode_netascii;
    logic [1:0]    err_code;

    int checks = 0;
    int failures = 0;

    rrq_parse #(.AW(AW)) dut (
        .clk(clk), .reset(reset), .en(en), .eth_data(eth_data), .req(req),
        .eof(eof), .name_addr(name_addr), .name_data(name_data),
        .name_len(name_len), .done(done), .valid(valid), .err(err),
        .err_code(err_code), .mode_netascii(mode_netascii)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int ev[$];              // consumed bytes; -1 marks an eof event
    int name_m [0:MAXN-1];
    int e_done, e_valid, e_err, e_code, e_len, e_net;
    string s_oct = "octet";
    string s_net = "netascii";

    function automatic bit is_prefix(input int mq[$], input string t);
        if (mq.size() > t.len()) return 1'b0;
        foreach (mq[i]) if (mq[i] != int'(t[i])) return 1'b0;
        return 1'b1;
    endfunction

    task automatic evaluate();
        int phase;
        int mq[$];
        int b;
        e_done = 0; e_valid = 0; e_err = 0; e_code = 0; e_len = 0; e_net = 0;
        if (ev.size() == 0) return;
        phase = 1;
        foreach (ev[k]) begin
            if (e_done != 0) break;
            b = ev[k];
            if (b < 0) begin
                e_done = 1; e_err = 1; e_code = 3;
            end else if (phase == 1) begin
                if (b == 0) begin
                    if (e_len == 0) begin e_done = 1; e_err = 1; e_code = 1; end
                    else phase = 2;
                end else if (e_len == MAXN) begin
                    e_done = 1; e_err = 1; e_code = 1;
                end else begin
                    name_m[e_len] = b;
                    e_len++;
                end
            end else begin
                if (b >= 65 && b <= 90) b = b + 32;
                if (b == 0) begin
                    if (is_prefix(mq, s_oct) && mq.size() == s_oct.len()) begin
                        e_done = 1; e_valid = 1;
                    end else if (NET && is_prefix(mq, s_net) && mq.size() == s_net.len()) begin
                        e_done = 1; e_valid = 1; e_net = 1;
                    end else begin
                        e_done = 1; e_err = 1; e_code = 2;
                    end
                end else begin
                    mq.push_back(b);
                    if (!(is_prefix(mq, s_oct) || (NET && is_prefix(mq, s_net)))) begin
                        e_done = 1; e_err = 1; e_code = 2;
                    end
                end
            end
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            ev.delete();
        end else begin
            if (en && (ev.size() > 0 || req)) ev.push_back(int'(eth_data));
            if (eof && ev.size() > 0) ev.push_back(-1);
        end
        evaluate();
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, expv, $time);
        end
    endtask

    // per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (!reset) begin
            chk("done",     32'(done),          32'(e_done));
            chk("valid",    32'(valid),         32'(e_valid));
            chk("err",      32'(err),           32'(e_err));
            chk("err_code", 32'(err_code),      32'(e_code));
            chk("name_len", 32'(name_len),      32'(e_len));
            chk("netascii", 32'(mode_netascii), 32'(e_net));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input bit e, input logic [7:0] b, input bit r, input bit f);
        @(posedge clk); #1;
        en = e; eth_data = b; req = r; eof = f;
    endtask

    task automatic send_str(input string s, input bit r, input int gap);
        for (int i = 0; i < s.len(); i++) begin
            drive(1'b1, s[i], r, 1'b0);
            if (gap > 0) repeat (gap) drive(1'b0, 8'h00, r, 1'b0);
        end
    endtask

    task automatic settle();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1; en = 1'b0; eof = 1'b0; req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic rd(input int a, input int lit);
        int mexp;
        @(posedge clk); #1;
        name_addr = AW'(a);
        @(posedge clk); #1;
        mexp = (a < e_len) ? name_m[a] : 0;
        chk("rd_model", 32'(name_data), 32'(mexp));
        chk("rd_lit",   32'(name_data), 32'(lit));
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_data", 32'(name_data), 32'd0);
        reset = 1'b0;

        // valid octet request, eof after completion
        send_str("a.txt", 1'b1, 0);
        drive(1'b1, 8'h00, 1'b1, 1'b0);
        send_str("octet", 1'b1, 0);
        drive(1'b1, 8'h00, 1'b1, 1'b0);
        drive(1'b0, 8'h00, 1'b1, 1'b1);
        settle();
        chk("t1_valid", 32'(valid), 32'd1);
        chk("t1_err",   32'(err),   32'd0);
        chk("t1_len",   32'(name_len), 32'd5);
        rd(0, 8'h61); rd(1, 8'h2E); rd(2, 8'h74); rd(3, 8'h78); rd(4, 8'h74); rd(5, 8'h00);

        // case folding with en gaps
        do_reset();
        send_str("f", 1'b1, 2);
        drive(1'b1, 8'h00, 1'b1, 1'b0);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        send_str("OcTeT", 1'b1, 1);
        drive(1'b1, 8'h00, 1'b1, 1'b0);
        settle();
        chk("t2_valid", 32'(valid), 32'd1);
        chk("t2_len",   32'(name_len), 32'd1);
        chk("t2_net",   32'(mode_netascii), 32'd0);

        // 33-byte name overflows on the 33rd byte
        do_reset();
        for (int i = 0; i < 32; i++) drive(1'b1, 8'h41, 1'b1, 1'b0);
        drive(1'b1, 8'h41, 1'b1, 1'b0);
        chk("t3_pre_done", 32'(done), 32'd0);
        settle();
        chk("t3_err",  32'(err), 32'd1);
        chk("t3_code", 32'(err_code), 32'd1);

        // 32-byte name is legal
        do_reset();
        for (int i = 0; i < 32; i++) drive(1'b1, 8'h41, 1'b1, 1'b0);
        drive(1'b1, 8'h00, 1'b1, 1'b0);
        send_str("octet", 1'b1, 0);
        drive(1'b1, 8'h00, 1'b1, 1'b0);
        settle();
        chk("t4_valid", 32'(valid), 32'd1);
        chk("t4_len",   32'(name_len), 32'd32);
        rd(31, 8'h41);

        // bad mode
        do_reset();
        send_str("x", 1'b1, 0);
        drive(1'b1, 8'h00, 1'b1, 1'b0);
        send_str("mail", 1'b1, 0);
        drive(1'b1, 8'h00, 1'b1, 1'b0);
        settle();
        chk("t5_code", 32'(err_code), 32'd2);

        // non-null sixth mode byte
        do_reset();
        send_str("x", 1'b1, 0);
        drive(1'b1, 8'h00, 1'b1, 1'b0);
        send_str("octetx", 1'b1, 0);
        settle();
        chk("t6_code", 32'(err_code), 32'd2);

        // netascii
        do_reset();
        send_str("x", 1'b1, 0);
        drive(1'b1, 8'h00, 1'b1, 1'b0);
        send_str("netascii", 1'b1, 0);
        drive(1'b1, 8'h00, 1'b1, 1'b0);
        settle();
`ifdef RRQ_NETASCII_EN
        chk("t7_valid", 32'(valid), 32'd1);
        chk("t7_net",   32'(mode_netascii), 32'd1);
`else
        chk("t7_code",  32'(err_code), 32'd2);
        chk("t7_net",   32'(mode_netascii), 32'd0);
`endif

        // truncated mode
        do_reset();
        send_str("x", 1'b1, 0);
        drive(1'b1, 8'h00, 1'b1, 1'b0);
        send_str("oct", 1'b1, 0);
        drive(1'b0, 8'h00, 1'b1, 1'b1);
        settle();
        chk("t8_code", 32'(err_code), 32'd3);

        // final terminator together with eof
        do_reset();
        send_str("x", 1'b1, 0);
        drive(1'b1, 8'h00, 1'b1, 1'b0);
        send_str("octet", 1'b1, 0);
        drive(1'b1, 8'h00, 1'b1, 1'b1);
        settle();
        chk("t9_valid", 32'(valid), 32'd1);
        chk("t9_err",   32'(err), 32'd0);

        // non-request packet
        do_reset();
        send_str("zz", 1'b0, 0);
        drive(1'b1, 8'h00, 1'b0, 1'b1);
        settle();
        chk("t10_done", 32'(done), 32'd0);

        // reset in the middle of the name, then a fresh request
        do_reset();
        send_str("abc", 1'b1, 0);
        settle();
        rd(0, 8'h61);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("t11_len",  32'(name_len), 32'd0);
        chk("t11_data", 32'(name_data), 32'd0);
        chk("t11_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        send_str("zz", 1'b1, 0);
        drive(1'b1, 8'h00, 1'b1, 1'b0);
        send_str("octet", 1'b1, 0);
        drive(1'b1, 8'h00, 1'b1, 1'b0);
        settle();
        chk("t12_valid", 32'(valid), 32'd1);
        chk("t12_len",   32'(name_len), 32'd2);
        rd(1, 8'h7A);
        rd(2, 8'h00);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
